mul_div_32: RTL and testbench

MUL_DIV_32 -- requirements
Module: mul_div_32

---
 rtl/mul_div_32.sv | 177 +++++++++++++++++
 tb/tb_mul_div_32.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_32.sv
// Iterative 32-bit unsigned multiply / divide unit (MUL, MULH, DIV, REM) with flag byte update.
// The divider is built only when MULDIV_DIVIDE_EN is defined; otherwise DIV/REM complete at once with a fixed result.
module mul_div_32 #(
  parameter int unsigned ITER_PER_CLK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [7:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  flags_out,
  output logic        div_by_zero
);

  localparam int unsigned CYCLES = 32 / ITER_PER_CLK;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        opnd_q, opnd_d;
  logic [63:0]        acc_q, acc_d;
  logic [4:0]         flg_q, flg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [7:0]         flags_q, flags_d;
  logic               dbz_q, dbz_d;

  logic [63:0]        acc_n_c;
  logic [31:0]        res_c;
  logic               dbz_c;
  logic               carry_c;
  logic               unused_flags_c;

  // carry/zero/negative are recomputed, so the incoming copies are not needed
  assign unused_flags_c = ^flags_in[2:0];

  // Shift-add step: {hi, lo} with the multiplier consumed from lo[0].
  function automatic logic [63:0] mul_step(input logic [63:0] p, input logic [31:0] m);
    logic [32:0] s;
    s = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
    return {s, p[31:1]};
  endfunction

`ifdef MULDIV_DIVIDE_EN
  // Restoring step: {remainder, dividend/quotient}; d == 0 yields all-ones quotient, remainder = dividend.
  function automatic logic [63:0] div_step(input logic [63:0] p, input logic [31:0] d);
    logic [32:0] r2;
    logic [33:0] diff;
    r2   = {p[63:32], p[31]};
    diff = {1'b0, r2} - {2'b00, d};
    if (!diff[33]) return {diff[31:0], p[30:0], 1'b1};
    return {r2[31:0], p[30:0], 1'b0};
  endfunction
`endif

  always_comb begin
    acc_n_c = acc_q;
    for (int unsigned i = 0; i < ITER_PER_CLK; i++) begin
`ifdef MULDIV_DIVIDE_EN
      acc_n_c = op_q[1] ? div_step(acc_n_c, opnd_q) : mul_step(acc_n_c, opnd_q);
`else
      acc_n_c = mul_step(acc_n_c, opnd_q);
`endif
    end
  end

  // op[0] selects the upper half for both MULH and REM
  assign res_c = op_q[0] ? acc_n_c[63:32] : acc_n_c[31:0];
`ifdef MULDIV_DIVIDE_EN
  assign dbz_c = op_q[1] && (opnd_q == 32'd0);
`else
  assign dbz_c = 1'b0;
`endif
  assign carry_c = op_q[1] ? dbz_c : (!op_q[0] && (acc_n_c[63:32] != 32'd0));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    flg_d    = flg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          flg_d   = flags_in[7:3];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
`ifdef MULDIV_DIVIDE_EN
          acc_d   = {32'd0, op[1] ? a : b};
          opnd_d  = op[1] ? b : a;
`else
          acc_d   = {32'd0, b};
          opnd_d  = a;
          if (op[1]) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = 32'd0;
            flags_d  = {flags_in[7:3], 3'b011};
            dbz_d    = 1'b0;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = acc_n_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = res_c;
          flags_d  = {flg_q, res_c[31], (res_c == 32'd0), carry_c};
          dbz_d    = dbz_c;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      flg_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      flg_q    <= flg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign flags_out   = flags_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_32.sv
// Self-checking bench for mul_div_32: directed scenarios plus random back-to-back ops against an arithmetic model.
module tb_mul_div_32;

  localparam int unsigned ITER = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  flags_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [7:0]  flags_out;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  mul_div_32 #(.ITER_PER_CLK(ITER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flags_in    (flags_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .flags_out   (flags_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [7:0] fl, output logic [31:0] r, output logic [7:0] f,
                                output logic z, output int lat);
    logic [63:0] p;
    logic        c;
    p   = 64'(x) * 64'(y);
    z   = 1'b0;
    c   = 1'b0;
    lat = 32 / ITER + 1;
    case (o)
      2'd0: begin r = p[31:0]; c = (p[63:32] != 32'd0); end
      2'd1: begin r = p[63:32]; c = 1'b0; end
      default: begin
`ifdef MULDIV_DIVIDE_EN
        if (y == 32'd0) begin
          z = 1'b1;
          r = (o == 2'd2) ? 32'hFFFF_FFFF : x;
        end else begin
          r = (o == 2'd2) ? x / y : x % y;
        end
        c = z;
`else
        r   = 32'd0;
        c   = 1'b1;
        lat = 1;
`endif
      end
    endcase
    f = {fl[7:3], r[31], (r == 32'd0), c};
  endfunction

  // Issue one op, optionally poke start at cycle 'poke' while busy, then check completion.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [7:0] fl, input int poke);
    logic [31:0] er;
    logic [7:0]  ef;
    logic        ez;
    int          lat;
    int          cyc;
    model(o, x, y, fl, er, ef, ez, lat);
    op = o; a = x; b = y; flags_in = fl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom; flags_in = 8'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      chk("busy_calc", 64'(busy), 64'd1);
      start = (cyc == poke);
      if (cyc == poke) begin a = 32'd9; b = 32'd9; op = 2'd0; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'(lat));
    chk("done_hi", 64'(done), 64'd1);
    chk("busy_done", 64'(busy), 64'd1);
    chk("result", 64'(result), 64'(er));
    chk("flags_out", 64'(flags_out), 64'(ef));
    chk("div_by_zero", 64'(div_by_zero), 64'(ez));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("result_hold", 64'(result), 64'(er));
  endtask

  initial begin
    logic        saw_done;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0; flags_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags_out), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'd0, 32'd7, 32'd6, 8'hA8, -1);
    chk("mul_7x6", 64'(result), 64'd42);
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, -1);
    chk("mul_max_carry", 64'(flags_out[0]), 64'd1);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, -1);
    chk("mulh_max", 64'(result), 64'hFFFF_FFFE);
    do_op(2'd2, 32'd100, 32'd7, 8'h55, -1);
    do_op(2'd3, 32'd100, 32'd7, 8'h0F, -1);
    do_op(2'd2, 32'h1234_5678, 32'd0, 8'h30, -1);
    do_op(2'd3, 32'h1234_5678, 32'd0, 8'hC0, -1);
    do_op(2'd0, 32'd3, 32'd4, 8'h10, 5);
    chk("busy_start_ignored", 64'(result), 64'd12);

    // Abort a MUL in CALC with reset.
    op = 2'd0; a = 32'd11; b = 32'd13; flags_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", 64'(flags_out), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    do_op(2'd0, 32'd5, 32'd5, 8'h00, -1);
    chk("mul_after_reset", 64'(result), 64'd25);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (i % 4 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      rb = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      do_op(ro, ra, rb, 8'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
